// File: rtl/if_pkg.sv
// if_pkg: state encoding, PC-source selects and default timeout shared by the fetch controller
package if_pkg;
  typedef enum logic [2:0] {ST_BOOT, ST_FETCH, ST_WAIT, ST_DRAIN, ST_ERR} state_t;
  localparam logic [1:0] PCSEL_INC   = 2'b00;
  localparam logic [1:0] PCSEL_BR    = 2'b01;
  localparam logic [1:0] PCSEL_SAVED = 2'b10;
  localparam logic [1:0] PCSEL_RST   = 2'b11;
  localparam int unsigned TIMEOUT_DEF = 16;
endpackage

// File: rtl/if_fetch_wdt.sv
// if_fetch_wdt: counts cycles of an unacknowledged memory request and flags the last allowed one
module if_fetch_wdt import if_pkg::*; #(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = run ? cnt_q + 8'd1 : 8'd0;
  always_ff @(posedge clk) cnt_q <= reset ? 8'd0 : cnt_d;
  assign expired = cnt_q == LIMIT;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch/redirect FSM; IF_FETCH_PERF_EN adds stall_cnt/wait_cnt counters
module if_fetch_ctrl import if_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] MEM_Latch,
  input  logic        stall,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] saved_target,
  output logic        latch_we,
  output logic        latch_flush,
  output logic        fetch_err
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] wait_cnt
`endif
);
  state_t state_q, state_d;
  logic [31:0] saved_q, saved_d;
  logic err_q, err_d;
  logic in_wait, expired, timeout, stalled_ack;
  // the PC mux sits outside; RESET_VECTOR names the value pc_sel=11 picks there
  logic unused_rst_vec;
  assign unused_rst_vec = ^RESET_VECTOR;
  assign in_wait = state_q == ST_WAIT || state_q == ST_DRAIN;
  assign timeout = in_wait && !mem_ack && expired;
  assign stalled_ack = (state_q == ST_FETCH || state_q == ST_WAIT) && mem_ack && stall && !PCSrc && !reset;
  if_fetch_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk     (clk),
    .reset   (reset),
    .run     (in_wait && state_d == state_q),
    .expired (expired)
  );
  always_ff @(posedge clk) begin
    state_q <= state_d;
    saved_q <= saved_d;
    err_q   <= err_d;
  end
  always_comb begin
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = (PCSrc || mem_ack) ? ST_FETCH : ST_WAIT;
      ST_WAIT:  state_d = mem_ack ? ST_FETCH : timeout ? ST_ERR : PCSrc ? ST_DRAIN : ST_WAIT;
      ST_DRAIN: state_d = mem_ack ? ST_FETCH : timeout ? ST_ERR : ST_DRAIN;
      default:  state_d = ST_ERR;
    endcase
    if (reset) state_d = ST_BOOT;
  end
  // a branch seen while a request is in flight is parked; the youngest one wins
  always_comb begin
    saved_d = reset ? 32'd0
            : (PCSrc && (state_q == ST_DRAIN || (state_q == ST_WAIT && !mem_ack))) ? MEM_Latch : saved_q;
    err_d   = !reset && (err_q || timeout);
  end
  always_comb begin
    mem_req     = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PCSEL_INC;
    latch_we    = 1'b0;
    latch_flush = 1'b0;
    case (state_q)
      ST_BOOT: begin
        pc_we       = 1'b1;
        pc_sel      = PCSEL_RST;
        latch_flush = 1'b1;
      end
      ST_FETCH, ST_WAIT: begin
        mem_req = 1'b1;
        if (PCSrc && (mem_ack || state_q == ST_FETCH)) begin
          pc_we       = 1'b1;
          pc_sel      = PCSEL_BR;
          latch_flush = 1'b1;
        end else if (mem_ack && !stall) begin
          pc_we    = 1'b1;
          latch_we = 1'b1;
        end
      end
      ST_DRAIN: begin
        mem_req     = 1'b1;
        pc_we       = mem_ack;
        latch_flush = mem_ack;
        pc_sel      = PCSrc ? PCSEL_BR : PCSEL_SAVED;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req     = 1'b0;
      pc_we       = 1'b0;
      latch_we    = 1'b0;
      latch_flush = 1'b1;
      pc_sel      = PCSEL_RST;
    end
  end
  assign saved_target = saved_q;
  assign fetch_err    = err_q;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, wait_cnt_q, wait_cnt_d;
  always_comb begin
    stall_cnt_d = reset ? 32'd0 : stall_cnt_q + 32'(stalled_ack && ~&stall_cnt_q);
    wait_cnt_d  = reset ? 32'd0 : wait_cnt_q + 32'(in_wait && ~&wait_cnt_q);
  end
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    wait_cnt_q  <= wait_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stalled_ack;
`endif
endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on the first cycle after reset.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles WAIT may last before error (range 2..255).
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 PCSrc  in  1  branch-taken pulse from MEM stage, one cycle per branch.
REQ-006 MEM_Latch  in  32  branch target, valid when PCSrc=1.
REQ-007 stall  in  1  hazard-unit stall request; level.
REQ-008 mem_ack  in  1  instruction memory data valid for the current request.
REQ-009 mem_req  out  1  instruction memory request; held high until mem_ack.
REQ-010 pc_we  out  1  Program Counter load enable.
REQ-011 pc_sel  out  2  PC source: 00 incremented, 01 MEM_Latch, 10 saved_target, 11 RESET_VECTOR.
REQ-012 saved_target  out  32  registered deferred-redirect target.
REQ-013 latch_we  out  1  IF/ID latch write enable.
REQ-014 latch_flush  out  1  IF/ID latch clear (bubble insert).
REQ-015 fetch_err  out  1  sticky memory-timeout error.

Function
REQ-016 States SHALL be BOOT, FETCH, WAIT, DRAIN, ERR.
REQ-017 BOOT: pc_we=1, pc_sel=11, latch_flush=1, mem_req=0; next state FETCH, unconditionally.
REQ-018 FETCH: mem_req=1; mem_ack=1 and stall=0 -> pc_we=1, pc_sel=00, latch_we=1, remain FETCH; mem_ack=1 and stall=1 -> no PC or latch write, remain FETCH (same PC refetched); mem_ack=0 -> WAIT.
REQ-019 WAIT: mem_req=1; on mem_ack, apply the FETCH mem_ack rules and return to FETCH.
REQ-020 PCSrc=1 in FETCH or WAIT with mem_ack=1 -> pc_we=1, pc_sel=01, latch_flush=1, latch_we=0, next FETCH.
REQ-021 PCSrc=1 in WAIT with mem_ack=0 -> capture MEM_Latch into saved_target, next DRAIN; mem_req stays high.
REQ-022 DRAIN: mem_req=1; on mem_ack -> data discarded, pc_we=1, pc_sel=10, latch_flush=1, next FETCH.
REQ-023 PCSrc=1 in DRAIN SHALL overwrite saved_target (youngest branch wins).
REQ-024 PCSrc SHALL take priority over stall in every state.
REQ-025 PCSrc in FETCH with mem_ack=0 -> redirect applied immediately per REQ-020 only when no request is outstanding; a request is outstanding once mem_req has been high for one cycle without mem_ack, in which case REQ-021 applies.
REQ-026 Wait counter SHALL clear on entry to WAIT or DRAIN and increment each cycle there; on reaching TIMEOUT -> fetch_err=1, next ERR.
REQ-027 ERR: all enables 0, mem_req=0, fetch_err=1; exit only via reset.
REQ-028 latch_flush and latch_we SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be combinational from state and inputs, except saved_target and fetch_err (registered).

Reset
REQ-030 reset=1 SHALL force BOOT next cycle from any state, clear saved_target, wait counter and fetch_err.
REQ-031 During reset cycle outputs: mem_req=0, pc_we=0, latch_we=0, latch_flush=1, pc_sel=11.
REQ-032 mem_ack arriving in BOOT (late ack from an aborted request) SHALL be ignored.

Configuration
REQ-033 Macro IF_FETCH_PERF_EN defined: add outputs stall_cnt[31:0] and wait_cnt[31:0], saturating counts of stalled-ack cycles and WAIT/DRAIN cycles, cleared by reset.
REQ-034 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-035 Package if_pkg SHALL hold the state enum, pc_sel encodings (PCSEL_INC, PCSEL_BR, PCSEL_SAVED, PCSEL_RST) and TIMEOUT default.
REQ-036 Sub-module if_fetch_wdt SHALL implement the wait counter and timeout compare; FSM stays in if_fetch_ctrl.

Verification
REQ-037 Reset released, mem_ack tied 1 -> cycle 1 pc_sel=11 pc_we=1; then pc_we=latch_we=1 every cycle, pc_sel=00.
REQ-038 mem_ack delayed 3 cycles -> WAIT 3 cycles with mem_req=1, pc_we=0; on ack pc_we=latch_we=1.
REQ-039 stall=1 for 2 cycles with mem_ack=1 -> pc_we=latch_we=0 both cycles; advance resumes cycle 3.
REQ-040 PCSrc=1, MEM_Latch=32'h0000_0040 during WAIT, ack 2 cycles later -> saved_target=0x40; ack cycle pc_sel=10, latch_flush=1.
REQ-041 PCSrc=1 and stall=1 same cycle with mem_ack=1 -> pc_sel=01, pc_we=1, latch_flush=1.
REQ-042 mem_ack held 0, TIMEOUT=16 -> fetch_err=1 after 16 WAIT cycles, mem_req=0; reset clears and reenters BOOT.
